uart_rx_fifo: RTL and testbench

Byte-wide receive FIFO between the `rs232rx` receiver and the `yarvi_soc` `rx_*` port. It absorbs bursts on the 115200 bps UART link while the CPU is busy and presents bytes in order on a valid/ready interface. It also records when a byte had to be dropped because the FIFO was full.

---
 rtl/uart_rx_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte receive FIFO between the UART receiver and the SoC rx port
// Optional saturating drop counter: define UART_RX_FIFO_DROP_COUNT_EN.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [7:0]            drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wp;
    logic [DEPTH_LOG2:0] rp;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;

    // Extra MSB on each pointer distinguishes full from empty when low bits match.
    assign empty = (wp == rp);
    assign full  = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                   (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = wp - rp;
    assign out_data  = mem[rp[DEPTH_LOG2-1:0]];

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;
    assign drop = in_valid && full;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wp[DEPTH_LOG2-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else if (drop) begin
            if (overflow_clr) begin
                drop_cnt_q <= 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (overflow_clr) begin
            drop_cnt_q <= 8'd0;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic [7:0] drop_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] popped[$];
    bit         m_ovf;
    int         m_drops;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow),
        .overflow_clr(overflow_clr),
        .drop_count(drop_count)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain queue plus flag and drop tally.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            int sz;
            bit drop;
            sz = q.size();
            drop = in_valid && (sz == DEPTH);
            if (out_ready && sz > 0) popped.push_back(q.pop_front());
            if (in_valid && sz < DEPTH) q.push_back(in_data);
            if (drop) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (DC_EN) begin
                if (drop) m_drops = overflow_clr ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
                else if (overflow_clr) m_drops = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("count", int'(count), q.size());
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
            if (q.size() != 0) chk("out_data", int'(out_data), int'(q[0]));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("drop_count", int'(drop_count), m_drops);
        end
    end

    task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit clr);
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        overflow_clr = clr;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        overflow_clr = 1'b0;
    endtask

    task automatic chk_popped(input string name, input logic [7:0] first, input int n);
        chk({name, "_len"}, popped.size(), n);
        for (int i = 0; i < n && i < popped.size(); i++)
            chk(name, int'(popped[i]), int'(first + 8'(i)));
        popped.delete();
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drop_count", int'(drop_count), 0);

        // In-order push then pop
        drive(1, 8'h41, 0, 0);
        drive(1, 8'h42, 0, 0);
        drive(1, 8'h43, 0, 0);
        chk("t1_count", int'(count), 3);
        chk("t1_head", int'(out_data), 8'h41);
        chk("t1_overflow", int'(overflow), 0);
        repeat (3) drive(0, 8'h00, 1, 0);
        chk("t1_out_valid", int'(out_valid), 0);
        chk_popped("t1_pop", 8'h41, 3);

        // Fill, drop one, drain
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0);
        chk("t2_in_ready", int'(in_ready), 0);
        chk("t2_count", int'(count), 16);
        drive(1, 8'hAA, 0, 0);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_drop_count", int'(drop_count), DC_EN ? 1 : 0);
        repeat (16) drive(0, 8'h00, 1, 0);
        chk_popped("t2_pop", 8'h00, 16);
        drive(0, 8'h00, 0, 1);
        chk("t2_clr", int'(overflow), 0);

        // Steady state at occupancy 1 across pointer wraps
        drive(1, 8'h80, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 8'h81 + 8'(i), 1, 0);
        chk("t3_count", int'(count), 1);
        chk("t3_head", int'(out_data), 8'hA8);
        chk_popped("t3_pop", 8'h80, 40);
        drive(0, 8'h00, 1, 0);
        popped.delete();

        // Saturating drop counter and clear/drop collision
        for (int i = 0; i < 16; i++) drive(1, 8'h10 + 8'(i), 0, 0);
        for (int i = 0; i < 300; i++) drive(1, 8'hEE, 0, 0);
        chk("t4_drop_sat", int'(drop_count), DC_EN ? 255 : 0);
        drive(1, 8'hEE, 0, 1);
        chk("t4_clr_drop_ovf", int'(overflow), 1);
        chk("t4_clr_drop_cnt", int'(drop_count), DC_EN ? 1 : 0);
        drive(0, 8'h00, 0, 1);
        chk("t4_clr_ovf", int'(overflow), 0);
        chk("t4_clr_cnt", int'(drop_count), 0);
        repeat (16) drive(0, 8'h00, 1, 0);
        chk_popped("t4_pop", 8'h10, 16);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) drive(1, 8'h60 + 8'(i), 0, 0);
        chk("t5_count_pre", int'(count), 5);
        #2 reset = 1'b1;
        #1;
        chk("t5_count", int'(count), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1, 8'h77, 0, 0);
        chk("t5_head", int'(out_data), 8'h77);
        chk("t5_count_post", int'(count), 1);
        drive(0, 8'h00, 1, 0);
        chk_popped("t5_pop", 8'h77, 1);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
